trit_spi_target: RTL and testbench
==================================

# trit_spi_target

Serial target (responder) for the two-lane trit link driven by `top`. Deserialises trits from `I_mosi` into a parallel word and serialises a preloaded word onto `O_miso`, oversampling the link clock in the `I_clk` domain. Sits at the far end of the link, or in the bench as a loop-back responder for `top`. Frames carry `TRITS` trits, MSB trit first.

## Interface
- `TRITS`, default 6: trits per frame.
- `SYNC`, default 2: synchroniser flop stages on `I_mosi`/`I_sck`.
- `I_clk`  in  1: system clock, all logic rising-edge.
- `I_rst`  in  1: synchronous, active-high reset.
- `I_sck`  in  2: bit 0 = link clock (idle 0); bit 1 = select, active low (idle 1).
- `I_mosi`  in  2: incoming trit.
- `O_miso`  out  2: outgoing trit.
- `I_tx_data`  in  2*TRITS: word to send; trit k in bits [2k+1:2k], trit TRITS-1 sent first.
- `I_tx_valid`  in  1: `I_tx_data` offered.
- `O_tx_ready`  out  1: holding register empty.
- `O_rx_data`  out  2*TRITS: last received word, same packing.
- `O_rx_valid`  out  1: one-cycle pulse, `O_rx_data` updated.
- `O_rx_err`  out  1: one-cycle pulse with `O_rx_valid`, word contained a 2'b11 trit.
- `O_frame_err`  out  1: one-cycle pulse, select released mid-frame.
- `O_tx_underrun`  out  1: one-cycle pulse, frame started with holding register empty.

## Operation
- Trit encoding: 2'b00 = 0, 2'b01 = +1, 2'b10 = -1, 2'b11 = invalid. Invalid trits are stored as received and flag `O_rx_err`.
- Input path: `I_sck` and `I_mosi` each pass through `SYNC` flops, then one more flop for edge detection. Events are: select-fall, select-rise, sck-rise, sck-fall, all on synchronised signals.
- Holding register: one entry. `I_tx_valid && O_tx_ready` captures `I_tx_data` and drops `O_tx_ready` next cycle. Ready rises the cycle after the register is loaded into the shifter.
- States:
  - IDLE: `O_miso` = 2'b00. On select-fall, go to SHIFT, clear the trit counter, and load the tx shifter from the holding register. If the register is empty, load all zeros and pulse `O_tx_underrun`. `O_miso` presents trit TRITS-1 from the next cycle.
  - SHIFT: on sck-rise, shift the synchronised `I_mosi` into the rx shifter LSB side and increment the counter. On sck-fall, shift the tx shifter and present the next trit. After the TRITS-th sck-rise go to DONE.
  - DONE: pulse `O_rx_valid` (and `O_rx_err` if any trit was 11) once, copy the rx shifter to `O_rx_data`, and go to WAIT.
  - WAIT: `O_miso` = 2'b00. Further sck edges are ignored. On select-rise go to IDLE.
- Select-rise while in SHIFT: pulse `O_frame_err`, leave `O_rx_data` unchanged, no `O_rx_valid`, go to IDLE. The shifted-out tx word is lost; it is not retried.
- Select-rise and sck-rise in the same cycle during SHIFT: select wins, abort as above.
- Reset mid-frame: everything returns to reset values, and the holding register is cleared. After reset the block waits for select-fall; a frame already in progress at reset release is ignored until select rises.

## Timing
- Reset values: `O_miso` 2'b00, `O_tx_ready` 1, `O_rx_data` 0, and all pulses 0. State is IDLE, and the synchroniser flops are set to sck=0, select=1.
- Event latency: pin edge to internal event is SYNC+1 `I_clk` cycles, 3 cycles at the default.
- `O_miso` change: SYNC+2 cycles after the pin edge (select-fall or sck-fall).
- `O_rx_valid`: SYNC+2 cycles after the final sck rising pin edge.
- Link constraint: sck high and low phases must each be at least SYNC+3 `I_clk` cycles. The master samples `O_miso` on sck-rise.
- Back-to-back frames: select must stay high for at least SYNC+2 cycles between frames.

## Test plan
- Reset: hold `I_rst` 3 cycles → `O_tx_ready`=1, `O_miso`=00, `O_rx_data`=0, no pulses.
- Nominal frame, TRITS=6:
  - Stimulus: load tx 12'b01_10_00_01_10_00; master sends +1,-1,0,0,+1,-1 with sck period 16 cycles.
  - Response: `O_rx_data`=12'b01_10_00_00_01_10 with one `O_rx_valid` pulse, `O_rx_err`=0.
  - Response: master captures 01,10,00,01,10,00 in order.
  - Response: `O_tx_ready` re-asserts the cycle after select-fall is detected.
- Invalid trit: send trit 2 as 2'b11 → `O_rx_valid` and `O_rx_err` pulse together, and bits [7:6]=11.
- Underrun: frame with no `I_tx_valid` beforehand → `O_tx_underrun` pulses once and the master reads six 00 trits.
- Abort: release select after 3 sck rises → `O_frame_err` pulses, there is no `O_rx_valid`, `O_rx_data` keeps its old value, and the next full frame is received correctly.
- Overrun edges and reset: send 8 sck pulses in one frame → exactly one `O_rx_valid` after the 6th and `O_miso`=00 afterward. Assert `I_rst` mid-frame → outputs return to reset values within 1 cycle.

Source files
------------

// File: rtl/trit_spi_target.sv
// Two-lane trit serial target: oversamples sck/select/mosi, deserialises rx frames, serialises a held tx word.
// Events land SYNC+1 cycles after a pin edge, miso/rx_valid SYNC+2; tx holding register is one entry (ready = empty).
module trit_spi_target #(
    parameter int TRITS = 6,
    parameter int SYNC  = 2
) (
    input  logic                 I_clk,
    input  logic                 I_rst,
    input  logic [1:0]           I_sck,
    input  logic [1:0]           I_mosi,
    output logic [1:0]           O_miso,
    input  logic [2*TRITS-1:0]   I_tx_data,
    input  logic                 I_tx_valid,
    output logic                 O_tx_ready,
    output logic [2*TRITS-1:0]   O_rx_data,
    output logic                 O_rx_valid,
    output logic                 O_rx_err,
    output logic                 O_frame_err,
    output logic                 O_tx_underrun
);

    localparam int W  = 2 * TRITS;
    localparam int CW = $clog2(TRITS + 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE, S_WAIT} state_t;

    state_t         state, state_nx;

    logic [1:0]     sck_sync  [SYNC];
    logic [1:0]     mosi_sync [SYNC];
    logic [1:0]     sck_d;
    logic [SYNC:0]  prime;

    logic [1:0]     sck_s;
    logic [1:0]     mosi_s;
    logic           live;
    logic           sel_fall, sel_rise, sck_rise, sck_fall;

    logic [CW-1:0]  cnt, cnt_nx;
    logic [W-1:0]   rx_sh, rx_sh_nx;
    logic [W-1:0]   tx_sh, tx_sh_nx;
    logic           hold_vld, hold_vld_nx;
    logic [W-1:0]   hold_dat, hold_dat_nx;
    logic [W-1:0]   rx_data_nx;
    logic [1:0]     miso_nx;
    logic           rx_valid_nx, rx_err_nx, frame_err_nx, underrun_nx;
    logic           any_bad;

    // Synchronisers plus one edge-detect stage; reset to link idle (sck=0, select=1).
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            for (int i = 0; i < SYNC; i++) begin
                sck_sync[i]  <= 2'b10;
                mosi_sync[i] <= 2'b00;
            end
            sck_d <= 2'b10;
            prime <= '0;
        end else begin
            sck_sync[0]  <= I_sck;
            mosi_sync[0] <= I_mosi;
            for (int i = 1; i < SYNC; i++) begin
                sck_sync[i]  <= sck_sync[i-1];
                mosi_sync[i] <= mosi_sync[i-1];
            end
            sck_d <= sck_sync[SYNC-1];
            prime <= {prime[SYNC-1:0], 1'b1};
        end
    end

    // Edges only count once the chain holds real pin samples, so a frame
    // already running at reset release cannot fake a select-fall.
    assign live     = prime[SYNC];
    assign sck_s    = sck_sync[SYNC-1];
    assign mosi_s   = mosi_sync[SYNC-1];
    assign sel_fall = live &  sck_d[1] & ~sck_s[1];
    assign sel_rise = live & ~sck_d[1] &  sck_s[1];
    assign sck_rise = live & ~sck_d[0] &  sck_s[0];
    assign sck_fall = live &  sck_d[0] & ~sck_s[0];

    assign O_tx_ready = ~hold_vld;

    always_comb begin
        any_bad = 1'b0;
        for (int k = 0; k < TRITS; k++) begin
            if (rx_sh[2*k +: 2] == 2'b11) begin
                any_bad = 1'b1;
            end
        end
    end

    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        rx_sh_nx     = rx_sh;
        tx_sh_nx     = tx_sh;
        hold_vld_nx  = hold_vld;
        hold_dat_nx  = hold_dat;
        rx_data_nx   = O_rx_data;
        rx_valid_nx  = 1'b0;
        rx_err_nx    = 1'b0;
        frame_err_nx = 1'b0;
        underrun_nx  = 1'b0;
        miso_nx      = (state == S_SHIFT) ? tx_sh[W-1 -: 2] : 2'b00;

        case (state)
            S_IDLE: begin
                if (sel_fall) begin
                    state_nx    = S_SHIFT;
                    cnt_nx      = '0;
                    rx_sh_nx    = '0;
                    tx_sh_nx    = hold_vld ? hold_dat : '0;
                    underrun_nx = ~hold_vld;
                    hold_vld_nx = 1'b0;
                end
            end
            S_SHIFT: begin
                // Select release beats a coincident sck-rise.
                if (sel_rise) begin
                    frame_err_nx = 1'b1;
                    state_nx     = S_IDLE;
                end else begin
                    if (sck_rise) begin
                        rx_sh_nx = {rx_sh[W-3:0], mosi_s};
                        cnt_nx   = cnt + CW'(1);
                        if (cnt == CW'(TRITS - 1)) begin
                            state_nx = S_DONE;
                        end
                    end
                    if (sck_fall) begin
                        tx_sh_nx = {tx_sh[W-3:0], 2'b00};
                    end
                end
            end
            S_DONE: begin
                rx_valid_nx = 1'b1;
                rx_err_nx   = any_bad;
                rx_data_nx  = rx_sh;
                state_nx    = sel_rise ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                if (sel_rise) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase

        if (I_tx_valid && !hold_vld) begin
            hold_vld_nx = 1'b1;
            hold_dat_nx = I_tx_data;
        end
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state         <= S_IDLE;
            cnt           <= '0;
            rx_sh         <= '0;
            tx_sh         <= '0;
            hold_vld      <= 1'b0;
            hold_dat      <= '0;
            O_rx_data     <= '0;
            O_miso        <= 2'b00;
            O_rx_valid    <= 1'b0;
            O_rx_err      <= 1'b0;
            O_frame_err   <= 1'b0;
            O_tx_underrun <= 1'b0;
        end else begin
            state         <= state_nx;
            cnt           <= cnt_nx;
            rx_sh         <= rx_sh_nx;
            tx_sh         <= tx_sh_nx;
            hold_vld      <= hold_vld_nx;
            hold_dat      <= hold_dat_nx;
            O_rx_data     <= rx_data_nx;
            O_miso        <= miso_nx;
            O_rx_valid    <= rx_valid_nx;
            O_rx_err      <= rx_err_nx;
            O_frame_err   <= frame_err_nx;
            O_tx_underrun <= underrun_nx;
        end
    end

endmodule

// File: tb/tb_trit_spi_target.sv
// Bench for trit_spi_target: a link master drives frames, a scoreboard queue holds expected rx words and miso trits.
module tb_trit_spi_target;

    logic        I_clk = 1'b0;
    logic        I_rst;
    logic [1:0]  I_sck;
    logic [1:0]  I_mosi;
    logic [1:0]  O_miso;
    logic [11:0] I_tx_data;
    logic        I_tx_valid;
    logic        O_tx_ready;
    logic [11:0] O_rx_data;
    logic        O_rx_valid;
    logic        O_rx_err;
    logic        O_frame_err;
    logic        O_tx_underrun;

    trit_spi_target #(.TRITS(6), .SYNC(2)) dut (
        .I_clk         (I_clk),
        .I_rst         (I_rst),
        .I_sck         (I_sck),
        .I_mosi        (I_mosi),
        .O_miso        (O_miso),
        .I_tx_data     (I_tx_data),
        .I_tx_valid    (I_tx_valid),
        .O_tx_ready    (O_tx_ready),
        .O_rx_data     (O_rx_data),
        .O_rx_valid    (O_rx_valid),
        .O_rx_err      (O_rx_err),
        .O_frame_err   (O_frame_err),
        .O_tx_underrun (O_tx_underrun)
    );

    always #5 I_clk = ~I_clk;

    int          vectors     = 0;
    int          miscompares = 0;
    int          vld_cnt     = 0;
    int          ferr_cnt    = 0;
    int          under_cnt   = 0;
    logic [12:0] rx_q [$];
    logic [1:0]  mq   [$];
    bit          hold_full = 0;
    logic [11:0] hold_word = '0;
    logic [11:0] last_rx   = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge I_clk);
    endtask

    always @(negedge I_clk) begin
        if (!I_rst) begin
            if (O_rx_valid) begin
                logic [12:0] e;
                vld_cnt++;
                check("rx_q_depth", rx_q.size(), 1);
                if (rx_q.size() > 0) begin
                    e = rx_q.pop_front();
                    check("rx_data_word", O_rx_data, e[11:0]);
                    check("rx_err_flag", O_rx_err, e[12]);
                end
            end
            if (O_rx_err) check("rx_err_with_vld", O_rx_valid, 1);
            if (O_frame_err) ferr_cnt++;
            if (O_tx_underrun) under_cnt++;
        end
    end

    task automatic load(input logic [11:0] d);
        check("rdy_pre_load", O_tx_ready, 1);
        I_tx_valid = 1'b1;
        I_tx_data  = d;
        tick(1);
        I_tx_valid = 1'b0;
        check("rdy_drop", O_tx_ready, 0);
        hold_full = 1;
        hold_word = d;
        tick(2);
    endtask

    // mw: word the master sends, first trit in [11:10]; abort_after < 0 means no abort.
    task automatic frame(input logic [11:0] mw, input int nsck, input int abort_after);
        logic [11:0] txw;
        bit          loaded;
        bit          full;
        logic        exp_err;
        logic [1:0]  em;
        loaded    = hold_full;
        txw       = hold_full ? hold_word : 12'h000;
        hold_full = 0;
        full      = (abort_after < 0) && (nsck >= 6);
        exp_err   = 1'b0;
        for (int k = 0; k < 6; k++) if (mw[2*k +: 2] == 2'b11) exp_err = 1'b1;
        for (int i = 0; i < nsck; i++) mq.push_back(i < 6 ? txw[11-2*i -: 2] : 2'b00);
        if (full) rx_q.push_back({exp_err, mw});
        vld_cnt = 0; ferr_cnt = 0; under_cnt = 0;

        I_mosi = mw[11:10];
        I_sck  = 2'b00;
        tick(2);
        if (loaded) check("rdy_still_low", O_tx_ready, 0);
        tick(1);
        check("rdy_after_sel_fall", O_tx_ready, 1);
        tick(5);
        for (int i = 0; i < nsck; i++) begin
            if (i == abort_after) break;
            I_sck[0] = 1'b1;
            em = mq.pop_front();
            check($sformatf("miso_trit%0d", i), O_miso, em);
            tick(8);
            I_sck[0] = 1'b0;
            I_mosi   = (i + 1 < 6) ? mw[9-2*i -: 2] : 2'b00;
            tick(8);
        end
        mq.delete();
        I_sck  = 2'b10;
        I_mosi = 2'b00;
        tick(10);
        if (full) last_rx = mw;
        check("vld_count", vld_cnt, full);
        check("frame_err_count", ferr_cnt, abort_after >= 0);
        check("underrun_count", under_cnt, !loaded);
        check("rx_q_drained", rx_q.size(), 0);
        check("rx_data_held", O_rx_data, last_rx);
        check("miso_idle", O_miso, 0);
    endtask

    initial begin
        I_rst      = 1'b1;
        I_sck      = 2'b10;
        I_mosi     = 2'b00;
        I_tx_data  = '0;
        I_tx_valid = 1'b0;
        tick(3);
        check("rst_ready", O_tx_ready, 1);
        check("rst_miso", O_miso, 0);
        check("rst_rx_data", O_rx_data, 0);
        check("rst_pulses", {O_rx_valid, O_rx_err, O_frame_err, O_tx_underrun}, 0);
        I_rst = 1'b0;
        tick(6);

        // Nominal frame: +1,-1,0,0,+1,-1 in, 01,10,00,01,10,00 out.
        load(12'b01_10_00_01_10_00);
        frame(12'b01_10_00_00_01_10, 6, -1);
        // Invalid trit in position 2 lands in [7:6].
        load(12'b10_01_10_01_10_01);
        frame(12'b01_10_11_00_01_10, 6, -1);
        // Underrun: nothing loaded, master reads zeros.
        frame(12'b10_10_01_01_00_00, 6, -1);
        // Abort after three rises, then a clean frame.
        load(12'b01_01_01_10_10_10);
        frame(12'b00_01_10_00_01_10, 6, 3);
        load(12'b00_01_10_10_01_00);
        frame(12'b10_00_01_10_00_01, 6, -1);
        // Eight sck pulses: only the first six count.
        load(12'b10_10_10_01_01_01);
        frame(12'b01_00_10_00_01_00, 8, -1);

        // Reset mid-frame with the holding register refilled.
        load(12'b01_01_10_10_00_01);
        I_mosi = 2'b01;
        I_sck  = 2'b00;
        tick(4);
        hold_full = 0;
        load(12'b10_00_10_00_10_00);
        I_sck[0] = 1'b1;
        tick(8);
        I_sck[0] = 1'b0;
        tick(4);
        I_rst = 1'b1;
        tick(1);
        check("midrst_miso", O_miso, 0);
        check("midrst_ready", O_tx_ready, 1);
        check("midrst_rx_data", O_rx_data, 0);
        check("midrst_pulses", {O_rx_valid, O_rx_err, O_frame_err, O_tx_underrun}, 0);
        tick(2);
        I_rst     = 1'b0;
        hold_full = 0;
        last_rx   = '0;
        vld_cnt = 0; ferr_cnt = 0; under_cnt = 0;
        // Frame still in progress at reset release is ignored.
        for (int i = 0; i < 6; i++) begin
            I_sck[0] = 1'b1;
            tick(8);
            I_sck[0] = 1'b0;
            tick(8);
        end
        check("stale_frame_vld", vld_cnt, 0);
        check("stale_frame_miso", O_miso, 0);
        I_sck = 2'b10;
        tick(10);
        check("stale_frame_ferr", ferr_cnt, 0);
        check("stale_frame_under", under_cnt, 0);
        frame(12'b01_01_00_10_10_00, 6, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
